// File: rtl/conv_seq.sv
// Sequencer for a 3x3 convolution over an image memory: streams nine pixel/tap
// operand pairs per window into an external PE and hands each result off with valid/ready.
module conv_seq #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flt_we,
  input  logic [3:0]        flt_addr,
  input  logic [7:0]        flt_data,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [7:0]        img_rdata,
  output logic              pe_rst,
  output logic [7:0]        pe_in,
  output logic [7:0]        pe_filter,
  input  logic [7:0]        pe_out,
  input  logic              pe_vaild,
  output logic [7:0]        res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_FEED = 3'd2,
    S_LAST = 3'd3,
    S_WAIT = 3'd4,
    S_HOLD = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] X_MAX = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] Y_MAX = ADDR_W'(IMG_H - 3);

  state_t            state_r;
  logic [7:0]        flt_r [0:8];
  logic [ADDR_W-1:0] x_r;
  logic [ADDR_W-1:0] y_r;
  logic [3:0]        k_r;
  logic [ADDR_W-1:0] nx_s;
  logic [ADDR_W-1:0] ny_s;
  logic              last_win_s;

  // Address of tap t (raster order inside the 3x3 window) for window origin (x,y).
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] x,
                                                 input logic [ADDR_W-1:0] y,
                                                 input logic [3:0]        t);
    logic [31:0] row;
    logic [31:0] col;
    logic [31:0] a;
    case (t)
      4'd0, 4'd1, 4'd2: row = 32'd0;
      4'd3, 4'd4, 4'd5: row = 32'd1;
      4'd6, 4'd7, 4'd8: row = 32'd2;
      default:          row = 32'd0;
    endcase
    case (t)
      4'd0, 4'd3, 4'd6: col = 32'd0;
      4'd1, 4'd4, 4'd7: col = 32'd1;
      4'd2, 4'd5, 4'd8: col = 32'd2;
      default:          col = 32'd0;
    endcase
    a = (32'(y) + row) * 32'(IMG_W) + 32'(x) + col;
    return a[ADDR_W-1:0];
  endfunction

  // Next window origin in raster order and last-window detection.
  always_comb begin
    last_win_s = (x_r == X_MAX) && (y_r == Y_MAX);
    if (x_r == X_MAX) begin
      nx_s = {ADDR_W{1'b0}};
      ny_s = y_r + ADDR_W'(1);
    end else begin
      nx_s = x_r + ADDR_W'(1);
      ny_s = y_r;
    end
  end

  // Memory read data lands one cycle after its address, so the pixel operand
  // must pass straight through in the cycle it arrives.
  assign pe_in = ((state_r == S_FEED) || (state_r == S_LAST)) ? img_rdata : 8'd0;

  // Window sequencer, filter bank and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      x_r       <= {ADDR_W{1'b0}};
      y_r       <= {ADDR_W{1'b0}};
      k_r       <= 4'd0;
      img_addr  <= {ADDR_W{1'b0}};
      pe_rst    <= 1'b1;
      pe_filter <= 8'd0;
      res_data  <= 8'd0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < 9; i++) flt_r[i] <= 8'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (flt_we && (flt_addr <= 4'd8)) flt_r[flt_addr] <= flt_data;
          if (start) begin
            state_r  <= S_CLR;
            x_r      <= {ADDR_W{1'b0}};
            y_r      <= {ADDR_W{1'b0}};
            img_addr <= tap_addr({ADDR_W{1'b0}}, {ADDR_W{1'b0}}, 4'd0);
            pe_rst   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_CLR: begin
          state_r   <= S_FEED;
          k_r       <= 4'd1;
          img_addr  <= tap_addr(x_r, y_r, 4'd1);
          pe_filter <= flt_r[0];
          pe_rst    <= 1'b0;
        end
        S_FEED: begin
          pe_filter <= flt_r[k_r];
          if (k_r == 4'd8) begin
            state_r <= S_LAST;
          end else begin
            k_r      <= k_r + 4'd1;
            img_addr <= tap_addr(x_r, y_r, k_r + 4'd1);
          end
        end
        S_LAST: begin
          state_r   <= S_WAIT;
          pe_filter <= 8'd0;
        end
        S_WAIT: begin
          if (pe_vaild) begin
            res_data  <= pe_out;
            res_valid <= 1'b1;
            state_r   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            pe_rst    <= 1'b1;
            if (last_win_s) begin
              state_r <= S_DONE;
              done    <= 1'b1;
            end else begin
              state_r  <= S_CLR;
              x_r      <= nx_s;
              y_r      <= ny_s;
              img_addr <= tap_addr(nx_s, ny_s, 4'd0);
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r   <= S_IDLE;
          pe_rst    <= 1'b1;
          pe_filter <= 8'd0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/conv_seq.md
CONV_SEQ -- requirements
Module: conv_seq

Interface
REQ-001 Parameter IMG_W, default 8: image width in pixels, minimum 3.
REQ-002 Parameter IMG_H, default 8: image height in pixels, minimum 3.
REQ-003 Parameter ADDR_W, default 6: image address width; 2^ADDR_W SHALL be at least IMG_W*IMG_H.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset: synchronous, active-low.
REQ-006 start  in  1  begin one full image pass; sampled in IDLE only.
REQ-007 flt_we  in  1  filter tap write strobe.
REQ-008 flt_addr  in  4  filter tap index 0..8, raster order (row*3+col).
REQ-009 flt_data  in  8  filter tap value.
REQ-010 img_addr  out  ADDR_W  image memory read address; read data returns one cycle later.
REQ-011 img_rdata  in  8  image memory read data.
REQ-012 pe_rst  out  1  active-high reset to the PE; clears its input regs and accumulator.
REQ-013 pe_in  out  8  pixel operand to the PE.
REQ-014 pe_filter  out  8  weight operand to the PE.
REQ-015 pe_out  in  8  PE result.
REQ-016 pe_vaild  in  1  PE result valid.
REQ-017 res_data  out  8  convolution result for the current window.
REQ-018 res_valid  out  1  result available; held until accepted.
REQ-019 res_ready  in  1  consumer accepts res_data when high with res_valid.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle pulse after the last result is accepted.

Function
REQ-022 States: IDLE, CLR, FEED, LAST, WAIT, HOLD, DONE.
REQ-023 Filter bank: 9 x 8-bit registers, written on flt_we in IDLE only; writes with flt_addr>8 or outside IDLE are ignored.
REQ-024 Window origin (x,y) walks raster order: x 0..IMG_W-3, then y 0..IMG_H-3, giving (IMG_W-2)*(IMG_H-2) windows per pass.
REQ-025 Tap t of a window reads address (y+t/3)*IMG_W + x + t%3, truncated to ADDR_W.
REQ-026 IDLE->CLR on start=1; (x,y) cleared to (0,0).
REQ-027 CLR, 1 cycle: pe_rst=1; img_addr=tap 0; pe_in=pe_filter=0.
REQ-028 FEED, 8 cycles, k=1..8: img_addr=tap k; pe_in=img_rdata (tap k-1); pe_filter=flt[k-1]; pe_rst=0.
REQ-029 LAST, 1 cycle: pe_in=img_rdata (tap 8); pe_filter=flt[8].
REQ-030 The PE SHALL therefore see exactly 9 consecutive operand beats, tap 0..8, starting the cycle after pe_rst falls.
REQ-031 WAIT: pe_in=pe_filter=0; on the first cycle pe_vaild=1, capture pe_out into res_data and go to HOLD.
REQ-032 HOLD: res_valid=1, res_data stable; on res_ready=1, either advance (x,y) and go to CLR, or go to DONE on the last window.
REQ-033 DONE, 1 cycle: done=1; then IDLE.
REQ-034 Outside FEED/LAST, pe_in and pe_filter SHALL be 0 and img_addr SHALL hold its last value.
REQ-035 Latency per window without backpressure: 10 cycles plus the PE delay to pe_vaild plus 1 HOLD cycle.
REQ-036 start outside IDLE SHALL be ignored; a new pass SHALL NOT begin until done has pulsed.
REQ-037 pe_vaild outside WAIT SHALL be ignored.
REQ-038 res_ready low SHALL stall in HOLD indefinitely; no PE activity during the stall.
REQ-039 res_data SHALL be pe_out unmodified (no extra width or saturation).

Reset
REQ-040 rst=0 at a clock edge SHALL force IDLE; clear filter bank, (x,y), res_data, img_addr, pe_in and pe_filter to 0; drive res_valid, busy and done to 0; and hold pe_rst=1.
REQ-041 Reset mid-pass SHALL abandon the pass with no result or done emitted; the next pass needs a new start.

Verification
REQ-042 IMG_W=IMG_H=4, all pixels 1, all taps 1, PE model with sum mod 256 -> 4 results of 9 in order (0,0),(1,0),(0,1),(1,1); done pulses once.
REQ-043 Pixel value = address, only flt[4]=1 -> results 5, 6, 9, 10.
REQ-044 res_ready held low 20 cycles in the first HOLD -> res_valid and res_data are stable and img_addr, pe_in and pe_filter are static; the pass resumes on release.
REQ-045 Assert start and flt_we mid-pass -> no restart and filter bank unchanged; the second start after done runs a full pass.
REQ-046 rst=0 during FEED of window 2 -> next cycle: IDLE, busy=0, res_valid=0, filter bank 0.
REQ-047 flt_addr=9..15 writes in IDLE -> taps 0..8 unchanged, read back via results.
